ifu_fetch_ctrl: RTL and testbench

Multicycle instruction fetch unit. It is the producer side of the instruction interface that the decode stage consumes: `inst`, `pc` and `snpc`. It issues word reads to instruction memory over a valid/ready request and valid response bus, and presents each fetched instruction to decode with a valid/ready handshake. It then waits for the execute stage to return the next PC (`dnpc`) before fetching again. Only one instruction is in flight at a time.

---
 rtl/ifu_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - multicycle instruction fetch controller, one instruction in flight
module ifu_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  input  logic            dnpc_valid,
  input  logic [XLEN-1:0] dnpc,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause,
  output logic [31:0]     fetch_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_EXEC,
    ST_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_BUS   = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [31:0]     inst_nxt;
  logic [1:0]      cause_nxt;
  logic [31:0]     count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      inst        <= '0;
      fault_cause <= 2'b00;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst        <= inst_nxt;
      fault_cause <= cause_nxt;
      fetch_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
    cause_nxt = fault_cause;
    count_nxt = fetch_count;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_nxt = ST_FAULT;
            cause_nxt = CAUSE_BUS;
          end else begin
            inst_nxt  = imem_rsp_data;
            state_nxt = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (inst_ready) begin
          count_nxt = fetch_count + 32'd1;
          state_nxt = ST_EXEC;
          // Execute may resolve in the same cycle decode accepts; skip EXEC then.
          if (dnpc_valid) begin
            pc_nxt = dnpc;
            if (dnpc[1:0] == 2'b00) begin
              state_nxt = ST_REQ;
            end else begin
              state_nxt = ST_FAULT;
              cause_nxt = CAUSE_ALIGN;
            end
          end
        end
      end
      ST_EXEC: begin
        if (dnpc_valid) begin
          pc_nxt = dnpc;
          if (dnpc[1:0] == 2'b00) begin
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_FAULT;
            cause_nxt = CAUSE_ALIGN;
          end
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (state == ST_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == ST_OUT);
  assign fetch_fault    = (state == ST_FAULT);
  assign snpc           = pc + XLEN'(4);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        dnpc_valid;
  logic [31:0] dnpc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  int tests  = 0;
  int failed = 0;

  ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .dnpc_valid     (dnpc_valid),
    .dnpc           (dnpc),
    .fetch_fault    (fetch_fault),
    .fault_cause    (fault_cause),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h8000_0000);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
    check({tag, "_cause"}, {30'b0, fault_cause}, 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    dnpc_valid     = 1'b0;
    dnpc           = 32'h0;

    // Reset then first request
    step();
    step();
    check_reset_values("rst0");
    check("rst0_snpc", snpc, 32'h8000_0004);
    rst = 1'b0;
    step();
    check("req1_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req1_addr", imem_req_addr, 32'h8000_0000);

    // Accept, respond two cycles after acceptance
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait1_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("wait1_no_inst", {31'b0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    check("out1_valid", {31'b0, inst_valid}, 32'd1);
    check("out1_inst", inst, 32'h0010_0093);
    check("out1_pc", pc, 32'h8000_0000);
    check("out1_snpc", snpc, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      step();
      check("out1_hold_valid", {31'b0, inst_valid}, 32'd1);
      check("out1_hold_inst", inst, 32'h0010_0093);
      check("out1_hold_pc", pc, 32'h8000_0000);
      check("out1_hold_snpc", snpc, 32'h8000_0004);
    end

    // Accept together with dnpc: straight to REQ
    inst_ready = 1'b1;
    dnpc_valid = 1'b1;
    dnpc       = 32'h8000_0010;
    step();
    inst_ready = 1'b0;
    dnpc_valid = 1'b0;
    check("fused_count", fetch_count, 32'd1);
    check("fused_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("req2_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req2_addr", imem_req_addr, 32'h8000_0010);
    check("req2_snpc", snpc, 32'h8000_0014);

    // Backpressure with a spurious response mid-window
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = (i == 1);
      imem_rsp_data  = 32'hdead_beef;
      step();
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_req_addr, 32'h8000_0010);
      check("stall_inst_valid", {31'b0, inst_valid}, 32'd0);
    end
    check("stall_inst_unchanged", inst, 32'h0010_0093);

    // Response coincident with acceptance is too early and ignored
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    step();
    check("min_lat_no_out", {31'b0, inst_valid}, 32'd0);
    check("min_lat_inst", inst, 32'h0010_0093);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0020_0113;
    step();
    imem_rsp_valid = 1'b0;
    check("out2_valid", {31'b0, inst_valid}, 32'd1);
    check("out2_inst", inst, 32'h0020_0113);

    // dnpc without inst_ready is ignored in OUT
    dnpc_valid = 1'b1;
    dnpc       = 32'h0000_1234;
    step();
    dnpc_valid = 1'b0;
    check("out2_dnpc_ignored_pc", pc, 32'h8000_0010);
    check("out2_still_valid", {31'b0, inst_valid}, 32'd1);

    // Accept alone, then misaligned dnpc in EXEC
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("exec_count", fetch_count, 32'd2);
    check("exec_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("exec_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("exec_waits", {31'b0, fetch_fault}, 32'd0);
    dnpc_valid = 1'b1;
    dnpc       = 32'h8000_0002;
    step();
    dnpc_valid = 1'b0;
    check("align_fault", {31'b0, fetch_fault}, 32'd1);
    check("align_cause", {30'b0, fault_cause}, 32'd2);
    check("align_pc", pc, 32'h8000_0002);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_no_req", {31'b0, imem_req_valid}, 32'd0);
      check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    end
    imem_req_ready = 1'b0;

    // Asynchronous reset from FAULT, then a bus error
    rst = 1'b1;
    #1;
    check_reset_values("rst1");
    rst = 1'b0;
    step();
    check("req3_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    check("bus_fault", {31'b0, fetch_fault}, 32'd1);
    check("bus_cause", {30'b0, fault_cause}, 32'd1);
    check("bus_inst_valid", {31'b0, inst_valid}, 32'd0);

    // Reset mid-WAIT, late response after release is ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_values("rst2");
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0bad_0bad;
    step();
    check("late_rsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("late_rsp_inst", inst, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    check("late_rsp2_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("late_rsp2_inst", inst, 32'h0);
    check("late_rsp2_req_valid", {31'b0, imem_req_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
